// File: rtl/operand_select_pipe_if.sv
// rtl/operand_select_pipe_if.sv - upstream/downstream signal bundle for the operand select stage
interface operand_select_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_illegal;
    logic                    out_valid;
    logic                    out_ready;
    logic [CNT_W-1:0]        illegal_cnt;

    modport master (
        output in_bus, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_sel, out_illegal, out_valid, illegal_cnt
    );

    modport slave (
        input  in_bus, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_sel, out_illegal, out_valid, illegal_cnt
    );
endinterface

// File: rtl/operand_select_pipe.sv
// rtl/operand_select_pipe.sv - registered N-way operand select with 2-entry skid buffer
module operand_select_pipe #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IN      = 4,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    operand_select_pipe_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             illegal;
    } entry_t;

    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry;
    logic             main_valid;
    logic             skid_valid;
    logic             accept;
    logic             sel_illegal;
    logic [WIDTH-1:0] mux_data;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        mux_data = DEFAULT_VAL;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                mux_data = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_illegal = (int'(bus.sel) >= NUM_IN);
    assign new_entry   = '{data: mux_data, sel: bus.sel, illegal: sel_illegal};
    assign accept      = bus.in_valid && bus.in_ready;

    // in_ready depends only on the skid flop, so out_ready never reaches it combinationally
    assign bus.in_ready    = !skid_valid;
    assign bus.out_valid   = main_valid;
    assign bus.out_data    = main_q.data;
    assign bus.out_sel     = main_q.sel;
    assign bus.out_illegal = main_q.illegal;
    assign bus.illegal_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            cnt_q      <= '0;
        end else begin
            // counted at accept even when a flush discards the entry
            if (accept && sel_illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (bus.flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid || bus.out_ready) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= accept;
                    if (accept) begin
                        skid_q <= new_entry;
                    end
                end else begin
                    main_valid <= accept;
                    if (accept) begin
                        main_q <= new_entry;
                    end
                end
            end else if (accept) begin
                skid_q     <= new_entry;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_operand_select_pipe.sv
// tb/tb_operand_select_pipe.sv - directed and randomised checks of operand_select_pipe
module tb_operand_select_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    operand_select_pipe_if #(.WIDTH(32), .NUM_IN(4),  .SEL_W(2), .CNT_W(8)) if_a ();
    operand_select_pipe_if #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2), .CNT_W(8)) if_b ();
    operand_select_pipe_if #(.WIDTH(8),  .NUM_IN(16), .SEL_W(4), .CNT_W(8)) if_c ();

    operand_select_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0), .CNT_W(8))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    operand_select_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEAD), .CNT_W(8))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    operand_select_pipe #(.WIDTH(8), .NUM_IN(16), .SEL_W(4), .DEFAULT_VAL(8'h0), .CNT_W(8))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0]  sb_q[$];
    logic [127:0] bus_c;
    logic [11:0]  exp_e;
    logic [7:0]   held;
    logic         hold_chk;
    logic         acc;
    logic         drn;
    int           ndone;
    int           cyc;

    initial begin
        rst_n = 1'b0;
        if_a.in_bus = {32'h44, 32'h33, 32'h22, 32'h11};
        if_a.sel = '0; if_a.in_valid = 1'b0; if_a.flush = 1'b0; if_a.out_ready = 1'b1;
        if_b.in_bus = {32'h33, 32'h22, 32'h11};
        if_b.sel = '0; if_b.in_valid = 1'b0; if_b.flush = 1'b0; if_b.out_ready = 1'b1;
        if_c.in_bus = '0;
        if_c.sel = '0; if_c.in_valid = 1'b0; if_c.flush = 1'b0; if_c.out_ready = 1'b1;
        repeat (2) tick();

        chk("rst_valid", if_a.out_valid, 0);
        chk("rst_data",  if_a.out_data, 0);
        chk("rst_ready", if_a.in_ready, 1);
        chk("rst_cnt",   if_b.illegal_cnt, 0);
        rst_n = 1'b1;

        // stream, no backpressure
        if_a.in_valid = 1'b1; if_a.sel = 2'd2;
        tick();
        chk("s1_valid", if_a.out_valid, 1);
        chk("s1_data",  if_a.out_data, 32'h33);
        chk("s1_sel",   if_a.out_sel, 2);
        chk("s1_ready", if_a.in_ready, 1);
        if_a.sel = 2'd0;
        tick();
        chk("s2_data",  if_a.out_data, 32'h11);
        chk("s2_ready", if_a.in_ready, 1);
        if_a.in_valid = 1'b0;
        tick();
        chk("s3_valid", if_a.out_valid, 0);
        chk("s3_hold",  if_a.out_data, 32'h11);

        // backpressure fills main then skid
        if_a.out_ready = 1'b0; if_a.in_valid = 1'b1; if_a.sel = 2'd1;
        tick();
        chk("bp1_data",  if_a.out_data, 32'h22);
        chk("bp1_ready", if_a.in_ready, 1);
        if_a.sel = 2'd3;
        tick();
        chk("bp2_data",  if_a.out_data, 32'h22);
        chk("bp2_ready", if_a.in_ready, 0);
        if_a.sel = 2'd0;
        tick();
        chk("bp3_data",  if_a.out_data, 32'h22);
        chk("bp3_valid", if_a.out_valid, 1);
        chk("bp3_ready", if_a.in_ready, 0);
        if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
        tick();
        chk("bp4_data",  if_a.out_data, 32'h44);
        chk("bp4_valid", if_a.out_valid, 1);
        chk("bp4_ready", if_a.in_ready, 1);
        tick();
        chk("bp5_valid", if_a.out_valid, 0);

        // illegal select
        if_b.in_valid = 1'b1; if_b.sel = 2'd3;
        tick();
        chk("il_data", if_b.out_data, 32'hDEAD);
        chk("il_flag", if_b.out_illegal, 1);
        chk("il_sel",  if_b.out_sel, 3);
        chk("il_cnt",  if_b.illegal_cnt, 1);
        if_b.sel = 2'd1;
        tick();
        chk("lg_data", if_b.out_data, 32'h22);
        chk("lg_flag", if_b.out_illegal, 0);
        chk("lg_cnt",  if_b.illegal_cnt, 1);

        // flush with both entries full; offered entry is not accepted
        if_b.out_ready = 1'b0; if_b.sel = 2'd0;
        tick();
        if_b.sel = 2'd2;
        tick();
        chk("fl_full", if_b.in_ready, 0);
        if_b.sel = 2'd3; if_b.flush = 1'b1;
        tick();
        chk("fl1_valid", if_b.out_valid, 0);
        chk("fl1_ready", if_b.in_ready, 1);
        chk("fl1_cnt",   if_b.illegal_cnt, 1);
        // flush with a simultaneous illegal accept
        if_b.flush = 1'b0; if_b.sel = 2'd0;
        tick();
        if_b.sel = 2'd3; if_b.flush = 1'b1;
        tick();
        chk("fl2_valid", if_b.out_valid, 0);
        chk("fl2_ready", if_b.in_ready, 1);
        chk("fl2_cnt",   if_b.illegal_cnt, 2);
        chk("fl2_hold",  if_b.out_data, 32'h11);
        if_b.flush = 1'b0; if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        tick();
        chk("fl3_valid", if_b.out_valid, 0);

        // saturation: 300 more illegal accepts from a count of 2
        if_b.in_valid = 1'b1; if_b.sel = 2'd3;
        repeat (252) tick();
        chk("sat_254", if_b.illegal_cnt, 254);
        repeat (48) tick();
        chk("sat_255", if_b.illegal_cnt, 255);
        if_b.in_valid = 1'b0;

        // reset in the middle of a stall
        if_a.out_ready = 1'b0; if_a.in_valid = 1'b1; if_a.sel = 2'd1;
        tick();
        if_a.sel = 2'd2;
        tick();
        chk("rs_full", if_a.in_ready, 0);
        rst_n = 1'b0; if_a.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_valid", if_a.out_valid, 0);
        chk("rs_data",  if_a.out_data, 0);
        chk("rs_sel",   if_a.out_sel, 0);
        chk("rs_ill",   if_a.out_illegal, 0);
        chk("rs_ready", if_a.in_ready, 1);
        chk("rs_cnt",   if_b.illegal_cnt, 0);
        if_a.out_ready = 1'b1; if_a.in_valid = 1'b1; if_a.sel = 2'd0;
        tick();
        chk("rs2_data",  if_a.out_data, 32'h11);
        chk("rs2_valid", if_a.out_valid, 1);
        if_a.in_valid = 1'b0;
        tick();
        chk("rs3_valid", if_a.out_valid, 0);

        // random valid/ready against an in-order scoreboard
        ndone = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        while (ndone < 10000 && cyc < 60000) begin
            if (hold_chk) begin
                chk("rnd_stable", {if_c.out_valid, if_c.out_data}, {1'b1, held});
            end
            bus_c = {$urandom, $urandom, $urandom, $urandom};
            if_c.in_bus    = bus_c;
            if_c.sel       = 4'($urandom_range(0, 15));
            if_c.in_valid  = ($urandom_range(0, 3) != 0);
            if_c.out_ready = ($urandom_range(0, 3) != 0);
            acc = if_c.in_valid && if_c.in_ready;
            drn = if_c.out_valid && if_c.out_ready;
            if (drn) begin
                exp_e = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hfff;
                chk("rnd_data", {if_c.out_sel, if_c.out_data}, exp_e);
                ndone++;
            end
            if (acc) begin
                sb_q.push_back({if_c.sel, bus_c[int'(if_c.sel)*8 +: 8]});
            end
            hold_chk = if_c.out_valid && !if_c.out_ready;
            held     = if_c.out_data;
            tick();
            cyc++;
        end
        chk("rnd_count", ndone, 10000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/operand_select_pipe.md
Name: operand_select_pipe

Overview:
- Parametrised, registered N-way operand selector for the CPU datapath.
- Generalises the fixed 2/3-way combinational register-address and operand selects to NUM_IN inputs of WIDTH bits each.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the select stage can stall without dropping operands.
- Defines behaviour for out-of-range selects: default value, flag and saturating counter; no latched or undefined outputs.

Parameters:
- WIDTH, 32, data width of each input and of out_data.
- NUM_IN, 4, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 0, out_data value for an illegal select.
- CNT_W, 8, width of the illegal-select saturating counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_bus  input  NUM_IN*WIDTH  packed inputs; input k = in_bus[k*WIDTH +: WIDTH].
- sel  input  SEL_W  input index.
- in_valid  input  1  upstream offers sel/in_bus.
- in_ready  output  1  stage can accept.
- flush  input  1  synchronous discard of all buffered entries.
- out_data  output  WIDTH  selected operand.
- out_sel  output  SEL_W  sel captured with out_data.
- out_illegal  output  1  captured sel was >= NUM_IN.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- illegal_cnt  output  CNT_W  count of accepted illegal selects, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_sel=0, out_illegal=0, illegal_cnt=0, skid empty, in_ready=1 on the following cycle. Reset overrides flush and all transfers.
- Accept occurs when in_valid && in_ready. The mux result is computed combinationally from in_bus/sel at accept and registered.
- Accept-to-out_valid latency is 1 cycle.
- Output transfer occurs when out_valid && out_ready.
- Storage is a main output register plus one skid register. in_ready = !skid_full and is a registered signal, with no combinational path from out_ready.
- Routing:
  - Main empty, or draining this cycle with skid empty: the accepted entry loads the main register.
  - Main full and not draining: the accepted entry loads the skid; in_ready drops next cycle.
  - Main draining with skid full: skid moves to main, and the new accept (if any) loads the skid.
- Entries leave in acceptance order (FIFO, depth 2).
- Illegal select (sel >= NUM_IN):
  - Entry carries out_data=DEFAULT_VAL and out_illegal=1.
  - illegal_cnt increments at accept and holds at 2**CNT_W-1.
  - Legal selects set out_illegal=0.
- flush=1:
  - At the edge, main and skid are emptied and out_valid=0; in_ready=1 next cycle.
  - Any accept in the same cycle is discarded.
  - illegal_cnt is not cleared; an illegal select accepted in the flush cycle is still counted.
- When out_valid=0, out_data/out_sel/out_illegal hold their last values (no X).
- When out_valid=1 and out_ready=0, outputs are stable until the transfer.
- in_bus changes after accept do not affect registered entries.

Test Plan:
- Reset then stream, NUM_IN=4, WIDTH=32, inputs 0x11,0x22,0x33,0x44, out_ready=1: sel=2 then sel=0 on consecutive cycles -> out_data=0x33 then 0x11, each 1 cycle after accept; in_ready stays 1.
- Backpressure: out_ready=0, accept sel=1 then sel=3 -> out_data=0x22 held; in_ready=0 after the second accept. Raise out_ready -> 0x22 then 0x44 in order, no loss or duplication; in_ready returns to 1.
- Illegal select, NUM_IN=3, SEL_W=2, sel=3, DEFAULT_VAL=0xDEAD -> out_data=0xDEAD, out_illegal=1, illegal_cnt=1. Then 300 illegal accepts with CNT_W=8 -> illegal_cnt saturates at 255.
- Flush with both entries full and a simultaneous accept -> out_valid=0 next cycle, in_ready=1, the accepted entry never appears, illegal_cnt unchanged except for a counted illegal sel.
- Reset mid-stall with skid full and rst_n=0 for 1 cycle -> all outputs 0, out_valid=0, in_ready=1, illegal_cnt=0. Subsequent accept sel=0 -> 0x11 after 1 cycle.
- Randomised valid/ready, 10k transfers, NUM_IN=16, WIDTH=8 -> scoreboard matches in_bus[sel] in order; out_data stable whenever out_valid && !out_ready.
